johnson_sequencer: RTL and testbench

JOHNSON_SEQUENCER -- requirements
Module: johnson_sequencer

---
 rtl/johnson_pkg.sv | 19 +
 rtl/johnson_sequencer_step.sv | 12 +
 rtl/johnson_sequencer.sv | 93 +++++++++
 tb/tb_johnson_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// johnson_pkg: shared FSM state type and terminal-code helper for johnson_sequencer
package johnson_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Code reached after `steps` advances from zero; dir=1 gives the mirror image.
    function automatic logic [63:0] term_code(input int width, input int steps, input logic dir);
        logic [63:0] f;
        logic [63:0] r;
        f = '0;
        r = '0;
        for (int i = 0; i < 64; i++)
            if (i < width) f[i] = (steps <= width) ? (i < steps) : (i >= steps - width);
        for (int i = 0; i < 64; i++)
            if (i < width) r[i] = f[width-1-i];
        return dir ? r : f;
    endfunction

endpackage

// File: rtl/johnson_sequencer_step.sv
// johnson_step: combinational one-position Johnson advance in either direction
module johnson_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] code_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] next_o
);

    assign next_o = dir_i ? {~code_i[0], code_i[WIDTH-1:1]} : {code_i[WIDTH-2:0], ~code_i[WIDTH-1]};

endmodule

// File: rtl/johnson_sequencer.sv
// johnson_sequencer: runs a Johnson counter for STEPS advances per start; JOHNSON_SEQUENCER_REVERSE_EN adds a dir port
module johnson_sequencer
    import johnson_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int STEPS = 32
) (
    input  logic             clock,
    input  logic             reset,
`ifdef JOHNSON_SEQUENCER_REVERSE_EN
    input  logic             dir,
`endif
    input  logic             start,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam logic [63:0] TERM_F = term_code(WIDTH, STEPS, 1'b0);
    localparam logic [63:0] TERM_R = term_code(WIDTH, STEPS, 1'b1);

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             busy_q;
    logic             done_q;
    logic             dir_q;
    logic             dir_in;
    logic [WIDTH-1:0] term;

`ifdef JOHNSON_SEQUENCER_REVERSE_EN
    assign dir_in = dir;
`else
    assign dir_in = 1'b0;
`endif

    assign term = dir_q ? TERM_R[WIDTH-1:0] : TERM_F[WIDTH-1:0];

    johnson_step #(.WIDTH(WIDTH)) u_step (
        .code_i (count_q),
        .dir_i  (dir_q),
        .next_o (count_d)
    );

    // FSM with registered busy/done; abort beats en in a run and beats start in IDLE
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start && !abort) begin
                    state_q <= RUN;
                    count_q <= '0;
                    busy_q  <= 1'b1;
                    dir_q   <= dir_in;
                end
                RUN: if (abort) begin
                    state_q <= IDLE;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                end else if (en) begin
                    count_q <= count_d;
                    if (count_d == term) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    if (abort) count_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_johnson_sequencer.sv
// tb_johnson_sequencer: directed self-checking bench for johnson_sequencer
module tb_johnson_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       en    = 1'b0;
    logic       abort = 1'b0;
    logic       start_b = 1'b0;
    logic [7:0] count, count_b;
    logic       busy, done, busy_b, done_b;
    logic       dir = 1'b0;
    int         checks = 0;
    int         failures = 0;

    always #5 clock = ~clock;

    johnson_sequencer #(.WIDTH(8), .STEPS(5)) dut_a (
        .clock (clock),
        .reset (reset),
`ifdef JOHNSON_SEQUENCER_REVERSE_EN
        .dir   (dir),
`endif
        .start (start),
        .en    (en),
        .abort (abort),
        .count (count),
        .busy  (busy),
        .done  (done)
    );

    johnson_sequencer #(.WIDTH(8), .STEPS(12)) dut_b (
        .clock (clock),
        .reset (reset),
`ifdef JOHNSON_SEQUENCER_REVERSE_EN
        .dir   (1'b0),
`endif
        .start (start_b),
        .en    (1'b1),
        .abort (1'b0),
        .count (count_b),
        .busy  (busy_b),
        .done  (done_b)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] fwd [4] = '{8'h01, 8'h03, 8'h07, 8'h0F};
        int n;
        bit seen;
        tick();
        tick();
        reset = 1'b0;
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count_b", count_b, 0);
        // basic run, STEPS=5
        en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_c1_count", count, 8'h00);
        check("run_c1_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("run_count", count, fwd[i]);
            check("run_busy", busy, 1);
            check("run_done", done, 0);
        end
        tick();
        check("term_count", count, 8'h1F);
        check("term_done", done, 1);
        check("term_busy", busy, 0);
        tick();
        check("idle_done", done, 0);
        check("idle_hold", count, 8'h1F);
        // start together with abort in IDLE: no run
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        check("idle_abort_start_busy", busy, 0);
        check("idle_abort_count", count, 8'h1F);
        tick();
        abort = 1'b0;
        check("idle_abort_only", count, 8'h1F);
        // STEPS=12 on the second instance
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done_b) seen = 1'b1;
            else begin
                if (busy_b) n++;
                tick();
            end
        end
        check("b_done_seen", seen, 1);
        check("b_busy_cycles", n, 12);
        check("b_term", count_b, 8'hF0);
        // stall for three cycles mid-run
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("stall_c2", count, 8'h01);
        tick();
        check("stall_c3", count, 8'h03);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", count, 8'h03);
            check("stall_busy", busy, 1);
        end
        en = 1'b1;
        tick();
        check("stall_c7", count, 8'h07);
        tick();
        check("stall_c8", count, 8'h0F);
        check("stall_c8_done", done, 0);
        tick();
        check("stall_c9", count, 8'h1F);
        check("stall_c9_done", done, 1);
        tick();
        // abort at 07 with start in the same cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("abort_pre", count, 8'h07);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_count", count, 8'h00);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        tick();
        check("abort_norun", busy, 0);
        check("abort_nodone", done, 0);
        // reset at 03 mid-run, overriding a held start
        start = 1'b1;
        tick();
        tick();
        tick();
        check("rstmid_pre", count, 8'h03);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rstmid_count", count, 8'h00);
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        tick();
        check("rstmid_nodone", done, 0);
        // start held through RUN and DONE
        start = 1'b1;
        tick();
        tick();
        tick();
        tick();
        tick();
        check("held_c5", count, 8'h0F);
        tick();
        check("held_done", done, 1);
        tick();
        check("held_idle_busy", busy, 0);
        check("held_idle_count", count, 8'h1F);
        start = 1'b0;
        tick();
        check("held_no_second", busy, 0);
`ifdef JOHNSON_SEQUENCER_REVERSE_EN
        begin
            logic [7:0] rev [4] = '{8'h80, 8'hC0, 8'hE0, 8'hF0};
            dir = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
            dir = 1'b0;
            check("rev_c1", count, 8'h00);
            for (int i = 0; i < 4; i++) begin
                tick();
                check("rev_count", count, rev[i]);
            end
            tick();
            check("rev_term", count, 8'hF8);
            check("rev_done", done, 1);
            tick();
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
